// File: rtl/axi_master_read_channel.sv
// axi_master_read_channel
//   Turns one line-fill request into a single INCR read burst on AXI AR/R.
//   It reassembles the returned narrow beats into one line. The line and an
//   error flag are returned through a valid/ready response port.
//
// Optional build macro: AXI_RD_TIMEOUT_EN
//   When defined, a watchdog aborts a stalled AR or R phase after
//   TIMEOUT_CYCLES cycles without a handshake. The response is then
//   returned with resp_err=1. When undefined, the block waits indefinitely.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   req_valid/req_ready : line request handshake, req_addr = line start
//   resp_valid/ready    : response handshake
//   resp_data           : assembled line, beat i at [i*READ_CHANNEL_WIDTH +: READ_CHANNEL_WIDTH]
//   resp_err            : burst had a bad RRESP, an early/late RLAST or a timeout
//   AR*                 : read address channel (master side)
//   R*                  : read data channel (master side)
module axi_master_read_channel #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 4,
  parameter int READ_BURST_LEN     = 8,
  parameter int BEATS              = 8,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  output logic                                 req_ready,
  output logic                                 resp_valid,
  output logic [READ_CHANNEL_WIDTH*BEATS-1:0]  resp_data,
  output logic                                 resp_err,
  input  logic                                 resp_ready,
  output logic                                 ARVALID,
  output logic [ADDR_WIDTH-1:0]                ARADDR,
  output logic [READ_BURST_LEN-1:0]            ARLEN,
  output logic [2:0]                           ARSIZE,
  output logic [1:0]                           ARBURST,
  input  logic                                 ARREADY,
  input  logic                                 RVALID,
  input  logic [READ_CHANNEL_WIDTH-1:0]        RDATA,
  input  logic                                 RLAST,
  input  logic [1:0]                           RRESP,
  output logic                                 RREADY
);

  localparam int LINE_WIDTH = READ_CHANNEL_WIDTH * BEATS;
  localparam int CNT_W      = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        beat_cnt;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    err_q;
  logic                    r_beat;
  logic                    timeout;

  assign r_beat = (state == DATA) && RVALID;

`ifdef AXI_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            stalled;

  // A cycle counts as stalled when the active channel has no handshake.
  assign stalled = ((state == ADDR) && !ARREADY) || ((state == DATA) && !RVALID);
  assign timeout = stalled && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wd_q <= '0;
    else if (stalled) wd_q <= wd_q + WD_W'(1);
    else              wd_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = ADDR;
      ADDR: begin
        if (ARREADY)      state_nxt = DATA;
        else if (timeout) state_nxt = RESP;
      end
      DATA: begin
        if (RVALID && RLAST) state_nxt = RESP;
        else if (timeout)    state_nxt = RESP;
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only; AR fields read zero outside ADDR.
  always_comb begin
    req_ready  = 1'b0;
    ARVALID    = 1'b0;
    ARADDR     = '0;
    ARLEN      = '0;
    ARSIZE     = 3'b000;
    ARBURST    = 2'b00;
    RREADY     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ADDR: begin
        ARVALID = 1'b1;
        ARADDR  = addr_q;
        ARLEN   = READ_BURST_LEN'(BEATS - 1);
        ARSIZE  = 3'b000;
        ARBURST = 2'b01;
      end
      DATA:    RREADY     = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  assign resp_data = line_q;
  assign resp_err  = err_q;

  // Request latch, beat assembly and error accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      beat_cnt <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        addr_q   <= req_addr;
        beat_cnt <= '0;
        line_q   <= '0;
        err_q    <= 1'b0;
      end
      if (r_beat) begin
        // Beats past the end of the line are accepted but not stored.
        if (beat_cnt < BEATS_C) begin
          for (int i = 0; i < BEATS; i++)
            if (beat_cnt == CNT_W'(i))
              line_q[i*READ_CHANNEL_WIDTH +: READ_CHANNEL_WIDTH] <= RDATA;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (RRESP != 2'b00) err_q <= 1'b1;
        // A saturated counter never equals LAST_IDX, so a late RLAST is flagged too.
        if (RLAST && (beat_cnt != LAST_IDX)) err_q <= 1'b1;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_master_read_channel.sv
module tb_axi_master_read_channel;

  localparam int AW = 32;
  localparam int W  = 4;
  localparam int BL = 8;
  localparam int BEATS = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [AW-1:0]     req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [W*BEATS-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;
  logic              ARVALID;
  logic [AW-1:0]     ARADDR;
  logic [BL-1:0]     ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARREADY;
  logic              RVALID;
  logic [W-1:0]      RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic              RREADY;

  axi_master_read_channel #(
    .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(W), .READ_BURST_LEN(BL),
    .BEATS(BEATS), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] last_exp_line;
  logic        last_exp_err;
  int          last_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle rules: exactly one of the four state indications is active,
  // and the AR control fields are fixed inside the address phase and zero outside it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_phase_active", 64'($countones({req_ready, ARVALID, RREADY, resp_valid})), 64'd1);
      if (ARVALID)
        chk("ar_fields", {ARLEN, ARSIZE, ARBURST}, {8'd7, 3'b000, 2'b01});
      else
        chk("ar_fields_idle", {ARLEN, ARSIZE, ARBURST}, 13'd0);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_ctrl_zero", {ARVALID, RREADY, resp_valid, resp_err}, 4'b0000);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_ar_zero", {ARADDR, ARLEN, ARSIZE, ARBURST}, 45'd0);
  endtask

  // One line fill. rv_mode: 0 = RVALID always high, 1 = toggles 1-0-1, 2 = random.
  // rst_after >= 0 asserts reset once that many beats have been accepted.
  task automatic do_txn(input logic [31:0] addr, input bit use_idx, input int ar_delay,
                        input int rv_mode, input int rlast_idx, input int bad_idx,
                        input int hold, input int rst_after);
    logic [3:0]  dat [0:15];
    logic [31:0] exp_line;
    logic        exp_err;
    logic        rv;
    logic        tog;
    int          b, guard, hs;
    exp_line = '0;
    exp_err  = (rlast_idx != BEATS - 1);
    for (int i = 0; i <= rlast_idx; i++) begin
      dat[i] = use_idx ? 4'(i) : 4'($urandom_range(0, 15));
      if (i < BEATS) exp_line[i*4 +: 4] = dat[i];
      if (i == bad_idx) exp_err = 1'b1;
    end
    last_exp_line = exp_line;
    last_exp_err  = exp_err;

    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    hs = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;

    // Address phase; junk on R must be ignored while RREADY is low.
    for (int d = 0; d < ar_delay; d++) begin
      chk("arvalid_wait", ARVALID, 1'b1);
      chk("araddr_wait", ARADDR, addr);
      ARREADY = 1'b0;
      RVALID = 1'b1; RDATA = 4'hF; RLAST = 1'b1; RRESP = 2'b11;
      @(negedge clk);
    end
    chk("arvalid", ARVALID, 1'b1);
    chk("araddr", ARADDR, addr);
    chk("rready_in_addr", RREADY, 1'b0);
    ARREADY = 1'b1;
    RVALID = 1'b1; RDATA = 4'hF; RLAST = 1'b1; RRESP = 2'b11;
    @(negedge clk);
    ARREADY = 1'b0;

    b = 0; guard = 0; tog = 1'b1;
    while (b <= rlast_idx && guard < 200) begin
      chk("rready_data", RREADY, 1'b1);
      case (rv_mode)
        0:       rv = 1'b1;
        1:       begin rv = tog; tog = ~tog; end
        default: rv = 1'($urandom_range(0, 1));
      endcase
      RVALID = rv;
      RDATA  = rv ? dat[b] : 4'hE;
      RRESP  = rv ? ((b == bad_idx) ? 2'b10 : 2'b00) : 2'b11;
      RLAST  = rv ? (b == rlast_idx) : 1'b1;
      @(negedge clk);
      guard++;
      if (rv) b++;
      if (rst_after >= 0 && b == rst_after) begin
        rst = 1'b1;
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1'b1);
        return;
      end
    end
    chk("beat_budget", guard < 200, 1'b1);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;

    chk("resp_valid", resp_valid, 1'b1);
    chk("rready_resp", RREADY, 1'b0);
    chk("resp_data", resp_data, exp_line);
    chk("resp_err", resp_err, exp_err);
    last_lat = cyc - hs;

    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = $urandom;
      @(negedge clk);
      chk("resp_valid_hold", resp_valid, 1'b1);
      chk("req_ready_hold", req_ready, 1'b0);
      chk("resp_data_hold", resp_data, exp_line);
      chk("resp_err_hold", resp_err, exp_err);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("resp_valid_done", resp_valid, 1'b0);
    chk("req_ready_done", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rl, bad;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back fill, beat index as data.
    do_txn(32'h0000_1000, 1'b1, 0, 0, 7, -1, 0, -1);
    chk("pin_line_basic", last_exp_line, 32'h7654_3210);
    chk("pin_err_basic", last_exp_err, 1'b0);
    chk("latency_basic", last_lat, 10);

    // Slow ARREADY and RVALID toggling.
    do_txn(32'h0000_2040, 1'b1, 5, 1, 7, -1, 0, -1);
    chk("pin_line_stall", last_exp_line, 32'h7654_3210);

    // Error response on beat 3.
    do_txn(32'h0000_3000, 1'b1, 0, 0, 7, 3, 0, -1);
    chk("pin_line_rresp", last_exp_line, 32'h7654_3210);
    chk("pin_err_rresp", last_exp_err, 1'b1);

    // Early RLAST on beat 5.
    do_txn(32'h0000_4000, 1'b1, 1, 0, 5, -1, 0, -1);
    chk("pin_line_early", last_exp_line, 32'h0054_3210);
    chk("pin_err_early", last_exp_err, 1'b1);

    // Late RLAST on beat 10.
    do_txn(32'h0000_5000, 1'b1, 0, 0, 10, -1, 0, -1);
    chk("pin_line_late", last_exp_line, 32'h7654_3210);
    chk("pin_err_late", last_exp_err, 1'b1);

    // Response back-pressure with a pending request.
    do_txn(32'h0000_6000, 1'b1, 0, 0, 7, -1, 4, -1);

    // Reset in the middle of the data phase.
    do_txn(32'h0000_7000, 1'b1, 0, 0, 7, -1, 0, 4);

    for (int t = 0; t < 25; t++) begin
      rl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : 7;
      bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl)) : -1;
      do_txn($urandom, 1'b0, int'($urandom_range(0, 4)), 2, rl, bad,
             int'($urandom_range(0, 3)), -1);
    end

`ifdef AXI_RD_TIMEOUT_EN
    begin
      int n;
      chk("to_req_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_addr = 32'h0000_8000;
      @(negedge clk);
      req_valid = 1'b0; ARREADY = 1'b1;
      @(negedge clk);
      ARREADY = 1'b0;
      n = 0;
      while (!resp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("to_idle_cycles", n, 16);
      chk("to_resp_err", resp_err, 1'b1);
      chk("to_resp_data", resp_data, 32'h0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("to_req_ready_done", req_ready, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
